// File: rtl/core_pkg.sv
// Shared definitions for the front end of the core: fetch FSM states,
// the NOP encoding used for IF/ID bubbles and the word/address width.
package core_pkg;

   localparam int WORD_W = 16;

   localparam logic [WORD_W-1:0] NOP_INST = 16'h0000;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2,
      HALT = 2'd3
   } fetch_state_t;

   // Addresses wrap silently at the top of the 16-bit space.
   function automatic logic [WORD_W-1:0] word_inc(input logic [WORD_W-1:0] a);
      return a + 16'd1;
   endfunction

endpackage

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register: loads a fetched beat or a bubble when enabled,
// holds otherwise, and powers up holding a bubble.
import core_pkg::*;

module fetch_ifid_reg (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              flush,
   input  logic [WORD_W-1:0] inst,
   input  logic [WORD_W-1:0] pcinc,
   output logic [WORD_W-1:0] inst_id,
   output logic [WORD_W-1:0] pcinc_id,
   output logic              flushed
);

   // A bubble carries NOP and a zero pcinc so decode sees a clean slot.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inst_id  <= NOP_INST;
         pcinc_id <= '0;
         flushed  <= 1'b1;
      end else if (en) begin
         if (flush) begin
            inst_id  <= NOP_INST;
            pcinc_id <= '0;
            flushed  <= 1'b1;
         end else begin
            inst_id  <= inst;
            pcinc_id <= pcinc;
            flushed  <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: PC, next-PC selection, instruction-memory request FSM
// and the IF/ID register. Optional perf counters are enabled by FETCH_PERF_CNT_EN.
import core_pkg::*;

module fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en_pc,
   input  logic              en_ifid,
   input  logic              flush_ifid,
   input  logic              jump_pred,
   input  logic [WORD_W-1:0] jump_pred_adr,
   input  logic              redirect_en,
   input  logic [WORD_W-1:0] redirect_adr,
   input  logic              is_halt_id,
   output logic              imem_req,
   output logic [WORD_W-1:0] imem_adr,
   input  logic              imem_valid,
   input  logic [WORD_W-1:0] imem_rdata,
   output logic [WORD_W-1:0] inst_id,
   output logic [WORD_W-1:0] pcinc_id,
`ifdef FETCH_PERF_CNT_EN
   output logic [15:0]       stall_cnt,
   output logic [15:0]       squash_cnt,
`endif
   output logic              flushed
);

   fetch_state_t      state, state_n;
   logic [WORD_W-1:0] pc, pc_n;
   logic [WORD_W-1:0] pend_pc, pend_pc_n;
   logic              halt_pend, halt_pend_n;
   logic              take_beat;
   logic              squash;
   logic              steer;
   logic [WORD_W-1:0] steer_adr;

   // Address is always the current pc: in DROP the old pc is kept on the bus
   // until the abandoned beat returns, and reset kills the request at once.
   assign imem_adr = pc;
   assign imem_req = reset && (state != HALT);

   // A resolved redirect outranks a predicted jump; prediction needs en_ifid
   // because it refers to the instruction currently sitting in IF/ID.
   assign steer     = redirect_en || (jump_pred && en_ifid);
   assign steer_adr = redirect_en ? redirect_adr : jump_pred_adr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= RUN;
         pc        <= RESET_PC;
         pend_pc   <= RESET_PC;
         halt_pend <= 1'b0;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         pend_pc   <= pend_pc_n;
         halt_pend <= halt_pend_n;
      end
   end

   // Next-state / next-PC. take_beat marks the only case where the returned
   // word goes into IF/ID; every other en_ifid=1 cycle loads a bubble.
   always_comb begin
      state_n     = state;
      pc_n        = pc;
      pend_pc_n   = pend_pc;
      halt_pend_n = halt_pend;
      take_beat   = 1'b0;
      squash      = 1'b0;
      unique case (state)
         RUN, WAIT: begin
            if (steer) begin
               if (imem_valid) begin
                  pc_n    = steer_adr;
                  state_n = RUN;
                  squash  = 1'b1;
               end else begin
                  pend_pc_n   = steer_adr;
                  halt_pend_n = 1'b0;
                  state_n     = DROP;
               end
            end else if (is_halt_id) begin
               if (imem_valid) begin
                  state_n = HALT;
               end else begin
                  pend_pc_n   = pc;
                  halt_pend_n = 1'b1;
                  state_n     = DROP;
               end
            end else if (imem_valid) begin
               state_n = RUN;
               if (en_ifid) begin
                  take_beat = 1'b1;
                  if (en_pc) begin
                     pc_n = word_inc(pc);
                  end
               end
            end else begin
               state_n = WAIT;
            end
         end
         DROP: begin
            if (redirect_en) begin
               pend_pc_n   = redirect_adr;
               halt_pend_n = 1'b0;
            end
            if (imem_valid) begin
               squash      = !(halt_pend && !redirect_en);
               pc_n        = redirect_en ? redirect_adr : pend_pc;
               state_n     = (halt_pend && !redirect_en) ? HALT : RUN;
               halt_pend_n = 1'b0;
            end
         end
         HALT: begin
            if (redirect_en) begin
               pc_n    = redirect_adr;
               state_n = RUN;
            end
         end
         default: begin
            state_n = RUN;
         end
      endcase
   end

   fetch_ifid_reg u_ifid (
      .clk      (clk),
      .reset    (reset),
      .en       (en_ifid),
      .flush    (flush_ifid || !take_beat),
      .inst     (imem_rdata),
      .pcinc    (word_inc(pc)),
      .inst_id  (inst_id),
      .pcinc_id (pcinc_id),
      .flushed  (flushed)
   );

`ifdef FETCH_PERF_CNT_EN
   // Both counters saturate rather than wrap so long runs stay meaningful.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt  <= '0;
         squash_cnt <= '0;
      end else begin
         if (imem_req && !imem_valid && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
         if (squash && (squash_cnt != 16'hFFFF)) begin
            squash_cnt <= squash_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch.sv
// Directed self-checking bench for fetch; memory answers combinationally
// with imem_adr ^ 16'hC3C3 whenever imem_valid is driven high.
`timescale 1ns/1ps

module tb_fetch;

   logic        clk;
   logic        reset;
   logic        en_pc;
   logic        en_ifid;
   logic        flush_ifid;
   logic        jump_pred;
   logic [15:0] jump_pred_adr;
   logic        redirect_en;
   logic [15:0] redirect_adr;
   logic        is_halt_id;
   logic        imem_req;
   logic [15:0] imem_adr;
   logic        imem_valid;
   logic [15:0] imem_rdata;
   logic [15:0] inst_id;
   logic [15:0] pcinc_id;
   logic        flushed;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] stall_cnt;
   logic [15:0] squash_cnt;
`endif

   int errors = 0;
   int checks = 0;

   fetch #(.RESET_PC(16'h0000)) dut (
      .clk           (clk),
      .reset         (reset),
      .en_pc         (en_pc),
      .en_ifid       (en_ifid),
      .flush_ifid    (flush_ifid),
      .jump_pred     (jump_pred),
      .jump_pred_adr (jump_pred_adr),
      .redirect_en   (redirect_en),
      .redirect_adr  (redirect_adr),
      .is_halt_id    (is_halt_id),
      .imem_req      (imem_req),
      .imem_adr      (imem_adr),
      .imem_valid    (imem_valid),
      .imem_rdata    (imem_rdata),
      .inst_id       (inst_id),
      .pcinc_id      (pcinc_id),
`ifdef FETCH_PERF_CNT_EN
      .stall_cnt     (stall_cnt),
      .squash_cnt    (squash_cnt),
`endif
      .flushed       (flushed)
   );

   assign imem_rdata = imem_adr ^ 16'hC3C3;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Advance across the next rising edge and settle; then back to the falling edge.
   task automatic edge_settle();
      @(posedge clk);
      #1;
   endtask

   task automatic to_neg();
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %b want 0", imem_req); end
      checks++;
      if (imem_adr !== 16'h0000) begin errors++; $display("[TB] FAIL reset_adr got %h want 0000", imem_adr); end
      checks++;
      if (inst_id !== 16'h0000 || pcinc_id !== 16'h0000 || flushed !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_ifid got inst=%h pcinc=%h fl=%b want 0000/0000/1", inst_id, pcinc_id, flushed);
      end
      to_neg();
   endtask

   task automatic test_sequential();
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (imem_req !== 1'b1 || imem_adr !== 16'(i)) begin
            errors++;
            $display("[TB] FAIL seq_adr got req=%b adr=%h want 1/%h", imem_req, imem_adr, 16'(i));
         end
         edge_settle();
         checks++;
         if (pcinc_id !== 16'(i + 1) || flushed !== 1'b0 || inst_id !== (16'(i) ^ 16'hC3C3)) begin
            errors++;
            $display("[TB] FAIL seq_ifid got inst=%h pcinc=%h fl=%b want %h/%h/0",
                     inst_id, pcinc_id, flushed, 16'(i) ^ 16'hC3C3, 16'(i + 1));
         end
         to_neg();
      end
   endtask

   task automatic test_wait();
      imem_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (imem_adr !== 16'h0005) begin errors++; $display("[TB] FAIL wait_adr got %h want 0005", imem_adr); end
         edge_settle();
         checks++;
         if (flushed !== 1'b1 || inst_id !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL wait_bubble got inst=%h fl=%b want 0000/1", inst_id, flushed);
         end
         to_neg();
      end
      imem_valid = 1'b1;
      checks++;
      if (imem_adr !== 16'h0005) begin errors++; $display("[TB] FAIL wait_adr_final got %h want 0005", imem_adr); end
      edge_settle();
      checks++;
      if (inst_id !== 16'hC3C6 || pcinc_id !== 16'h0006 || flushed !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wait_beat got inst=%h pcinc=%h fl=%b want c3c6/0006/0", inst_id, pcinc_id, flushed);
      end
      to_neg();
   endtask

   task automatic test_redirect();
      for (int i = 0; i < 3; i++) begin
         edge_settle();
         to_neg();
      end
      imem_valid = 1'b0;
      edge_settle();
      to_neg();
      redirect_en  = 1'b1;
      redirect_adr = 16'h0040;
      checks++;
      if (imem_adr !== 16'h0009) begin errors++; $display("[TB] FAIL redir_adr_pre got %h want 0009", imem_adr); end
      edge_settle();
      checks++;
      if (flushed !== 1'b1) begin errors++; $display("[TB] FAIL redir_bubble got fl=%b want 1", flushed); end
      to_neg();
      redirect_en = 1'b0;
      checks++;
      if (imem_adr !== 16'h0009 || imem_req !== 1'b1) begin
         errors++;
         $display("[TB] FAIL redir_adr_hold got req=%b adr=%h want 1/0009", imem_req, imem_adr);
      end
      edge_settle();
      to_neg();
      imem_valid = 1'b1;
      edge_settle();
      checks++;
      if (flushed !== 1'b1 || inst_id !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL redir_drop got inst=%h fl=%b want 0000/1", inst_id, flushed);
      end
      to_neg();
      checks++;
      if (imem_adr !== 16'h0040) begin errors++; $display("[TB] FAIL redir_target got %h want 0040", imem_adr); end
      edge_settle();
      checks++;
      if (pcinc_id !== 16'h0041 || inst_id !== 16'hC383) begin
         errors++;
         $display("[TB] FAIL redir_beat got inst=%h pcinc=%h want c383/0041", inst_id, pcinc_id);
      end
      to_neg();
   endtask

   task automatic test_jump();
      jump_pred     = 1'b1;
      jump_pred_adr = 16'h0020;
      en_pc         = 1'b0;
      edge_settle();
      checks++;
      if (flushed !== 1'b1) begin errors++; $display("[TB] FAIL jump_bubble got fl=%b want 1", flushed); end
      to_neg();
      jump_pred = 1'b0;
      en_pc     = 1'b1;
      checks++;
      if (imem_adr !== 16'h0020) begin errors++; $display("[TB] FAIL jump_target got %h want 0020", imem_adr); end
      edge_settle();
      to_neg();
   endtask

   task automatic test_wrap();
      redirect_en  = 1'b1;
      redirect_adr = 16'hFFFF;
      edge_settle();
      to_neg();
      redirect_en = 1'b0;
      checks++;
      if (imem_adr !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_adr got %h want ffff", imem_adr); end
      edge_settle();
      checks++;
      if (pcinc_id !== 16'h0000 || inst_id !== 16'h3C3C || flushed !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wrap_ifid got inst=%h pcinc=%h fl=%b want 3c3c/0000/0", inst_id, pcinc_id, flushed);
      end
      to_neg();
      checks++;
      if (imem_adr !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_next got %h want 0000", imem_adr); end
      edge_settle();
      to_neg();
   endtask

   task automatic test_halt();
      imem_valid = 1'b0;
      edge_settle();
      to_neg();
      is_halt_id = 1'b1;
      checks++;
      if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL halt_req_pending got %b want 1", imem_req); end
      edge_settle();
      to_neg();
      is_halt_id = 1'b0;
      imem_valid = 1'b1;
      checks++;
      if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL halt_req_drain got %b want 1", imem_req); end
      edge_settle();
      checks++;
      if (flushed !== 1'b1) begin errors++; $display("[TB] FAIL halt_bubble got fl=%b want 1", flushed); end
      to_neg();
      checks++;
      if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL halt_req_off got %b want 0", imem_req); end
      edge_settle();
      to_neg();
      checks++;
      if (imem_req !== 1'b0 || flushed !== 1'b1) begin
         errors++;
         $display("[TB] FAIL halt_stay got req=%b fl=%b want 0/1", imem_req, flushed);
      end
      redirect_en  = 1'b1;
      redirect_adr = 16'h0010;
      edge_settle();
      to_neg();
      redirect_en = 1'b0;
      checks++;
      if (imem_req !== 1'b1 || imem_adr !== 16'h0010) begin
         errors++;
         $display("[TB] FAIL halt_resume got req=%b adr=%h want 1/0010", imem_req, imem_adr);
      end
      edge_settle();
      checks++;
      if (pcinc_id !== 16'h0011 || flushed !== 1'b0) begin
         errors++;
         $display("[TB] FAIL halt_resume_ifid got pcinc=%h fl=%b want 0011/0", pcinc_id, flushed);
      end
      to_neg();
   endtask

   task automatic test_flush();
      flush_ifid = 1'b1;
      edge_settle();
      checks++;
      if (flushed !== 1'b1 || inst_id !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL flush_bubble got inst=%h fl=%b want 0000/1", inst_id, flushed);
      end
      to_neg();
      flush_ifid = 1'b0;
      checks++;
      if (imem_adr !== 16'h0012) begin errors++; $display("[TB] FAIL flush_adv got %h want 0012", imem_adr); end
      edge_settle();
      to_neg();
      flush_ifid = 1'b1;
      en_ifid    = 1'b0;
      edge_settle();
      checks++;
      if (flushed !== 1'b0 || pcinc_id !== 16'h0013) begin
         errors++;
         $display("[TB] FAIL flush_hold got pcinc=%h fl=%b want 0013/0", pcinc_id, flushed);
      end
      to_neg();
      flush_ifid = 1'b0;
      en_ifid    = 1'b1;
      checks++;
      if (imem_adr !== 16'h0013) begin errors++; $display("[TB] FAIL stall_adr got %h want 0013", imem_adr); end
      edge_settle();
      checks++;
      if (pcinc_id !== 16'h0014 || flushed !== 1'b0) begin
         errors++;
         $display("[TB] FAIL stall_release got pcinc=%h fl=%b want 0014/0", pcinc_id, flushed);
      end
      to_neg();
   endtask

   task automatic test_reset_mid();
      imem_valid = 1'b0;
      edge_settle();
      to_neg();
      reset = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b0 || flushed !== 1'b1 || imem_adr !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL reset_mid got req=%b fl=%b adr=%h want 0/1/0000", imem_req, flushed, imem_adr);
      end
      to_neg();
      reset      = 1'b1;
      imem_valid = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_adr !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL reset_release got req=%b adr=%h want 1/0000", imem_req, imem_adr);
      end
   endtask

   initial begin
      reset         = 1'b1;
      en_pc         = 1'b1;
      en_ifid       = 1'b1;
      flush_ifid    = 1'b0;
      jump_pred     = 1'b0;
      jump_pred_adr = 16'h0000;
      redirect_en   = 1'b0;
      redirect_adr  = 16'h0000;
      is_halt_id    = 1'b0;
      imem_valid    = 1'b1;
      #1;
      reset = 1'b0;
      test_reset();
      test_sequential();
      test_wait();
      test_redirect();
      test_jump();
      test_wrap();
      test_halt();
      test_flush();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
